// File: rtl/pipeline_stall_controller_if.sv
// pipeline_stall_controller_if: stall sources in, pipeline register enables/flushes out
interface pipeline_stall_controller_if #(parameter int CNT_WIDTH = 16);
  logic dm_stall;
  logic div_start;
  logic div_done;
  logic branch_taken;
  logic load_use_hazard;
  logic pc_enable;
  logic f_to_d_enable_ff;
  logic d_to_e_enable_ff;
  logic e_to_m_enable_ff;
  logic f_to_d_flush;
  logic d_to_e_flush;
  logic div_timeout_err;
  logic [CNT_WIDTH-1:0] stall_count;
  modport master (
    output dm_stall, div_start, div_done, branch_taken, load_use_hazard,
    input  pc_enable, f_to_d_enable_ff, d_to_e_enable_ff, e_to_m_enable_ff,
           f_to_d_flush, d_to_e_flush, div_timeout_err, stall_count
  );
  modport slave (
    input  dm_stall, div_start, div_done, branch_taken, load_use_hazard,
    output pc_enable, f_to_d_enable_ff, d_to_e_enable_ff, e_to_m_enable_ff,
           f_to_d_flush, d_to_e_flush, div_timeout_err, stall_count
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: arbitrates memory/divide/redirect/load-use stalls into register enables and flushes
module pipeline_stall_controller #(
  parameter int LOAD_BUBBLES = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int DIV_TIMEOUT  = 80,
  parameter int CNT_WIDTH    = 16
) (
  input logic clk,
  input logic rst,
  pipeline_stall_controller_if.slave bus
);
  localparam int MAXP = (DIV_TIMEOUT > LOAD_BUBBLES)
                        ? ((DIV_TIMEOUT > FLUSH_CYCLES) ? DIV_TIMEOUT : FLUSH_CYCLES)
                        : ((LOAD_BUBBLES > FLUSH_CYCLES) ? LOAD_BUBBLES : FLUSH_CYCLES);
  localparam int CW = $clog2(MAXP + 1);
  typedef enum logic [1:0] {RUN, LOAD_BUBBLE, BRANCH_FLUSH, DIV_WAIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic [CNT_WIDTH-1:0] sc_q;
  logic [3:0] en;
  logic ffl, dfl;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = err_q;
    en = 4'b1111;
    ffl = 1'b0;
    dfl = 1'b0;
    if (rst) begin
      en = 4'b0000;
      ffl = 1'b1;
      dfl = 1'b1;
    end else if (bus.dm_stall) begin
      en = 4'b0000;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.div_start) begin
            en = 4'b0000;
            state_d = DIV_WAIT;
            cnt_d = CW'(DIV_TIMEOUT - 1);
          end else if (bus.branch_taken) begin
            ffl = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = BRANCH_FLUSH;
              cnt_d = CW'(FLUSH_CYCLES - 2);
            end
          end else if (bus.load_use_hazard) begin
            en = 4'b0011;
            dfl = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              state_d = LOAD_BUBBLE;
              cnt_d = CW'(LOAD_BUBBLES - 2);
            end
          end
        end
        LOAD_BUBBLE: begin
          en = 4'b0011;
          dfl = 1'b1;
          state_d = (cnt_q == '0) ? RUN : LOAD_BUBBLE;
          cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        end
        BRANCH_FLUSH: begin
          ffl = 1'b1;
          state_d = (cnt_q == '0) ? RUN : BRANCH_FLUSH;
          cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        end
        default: begin
          // div_done wins over an expiring timeout in the same cycle
          if (bus.div_done) begin
            state_d = RUN;
          end else if (cnt_q == '0) begin
            err_d = 1'b1;
            state_d = RUN;
          end else begin
            en = 4'b0000;
            cnt_d = cnt_q - 1'b1;
          end
        end
      endcase
    end
  end
  assign bus.pc_enable        = en[3];
  assign bus.f_to_d_enable_ff = en[2];
  assign bus.d_to_e_enable_ff = en[1];
  assign bus.e_to_m_enable_ff = en[0];
  assign bus.f_to_d_flush     = ffl;
  assign bus.d_to_e_flush     = dfl;
  assign bus.div_timeout_err  = err_q;
  assign bus.stall_count      = sc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q <= '0;
      err_q <= 1'b0;
      sc_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (!en[3] && !(&sc_q)) sc_q <= sc_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed scenarios plus random stimulus against a remaining-cycles reference model
module tb_pipeline_stall_controller;
  localparam int LB = 2, FL = 3, DT = 80, CW = 8;
  localparam int SMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, failures = 0;
  pipeline_stall_controller_if #(.CNT_WIDTH(CW)) bus ();
  pipeline_stall_controller #(.LOAD_BUBBLES(LB), .FLUSH_CYCLES(FL), .DIV_TIMEOUT(DT), .CNT_WIDTH(CW))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // model: cycles still owed to each pending activity
  bit m_init = 0, m_div = 0, m_err = 0;
  int m_dw = 0, m_bub = 0, m_fl = 0, m_sc = 0;
  always @(negedge clk) begin
    logic [3:0] en;
    logic ff, df;
    en = 4'b1111; ff = 1'b0; df = 1'b0;
    if (rst) begin en = 4'b0000; ff = 1'b1; df = 1'b1; end
    else if (bus.dm_stall) en = 4'b0000;
    else if (m_div) begin if (!bus.div_done && m_dw > 0) en = 4'b0000; end
    else if (m_bub > 0) begin en = 4'b0011; df = 1'b1; end
    else if (m_fl > 0) ff = 1'b1;
    else if (bus.div_start) en = 4'b0000;
    else if (bus.branch_taken) ff = 1'b1;
    else if (bus.load_use_hazard) begin en = 4'b0011; df = 1'b1; end
    chk("model_ctrl", int'({bus.pc_enable, bus.f_to_d_enable_ff, bus.d_to_e_enable_ff,
        bus.e_to_m_enable_ff, bus.f_to_d_flush, bus.d_to_e_flush}), int'({en, ff, df}));
    if (m_init) begin
      chk("model_stall_count", int'(bus.stall_count), m_sc);
      chk("model_err", int'(bus.div_timeout_err), int'(m_err));
    end
    if (rst) begin
      m_init = 1; m_div = 0; m_err = 0; m_dw = 0; m_bub = 0; m_fl = 0; m_sc = 0;
    end else begin
      if (!en[3] && m_sc < SMAX) m_sc++;
      if (!bus.dm_stall) begin
        if (m_div) begin
          if (bus.div_done) m_div = 0;
          else if (m_dw == 0) begin m_div = 0; m_err = 1; end
          else m_dw--;
        end
        else if (m_bub > 0) m_bub--;
        else if (m_fl > 0) m_fl--;
        else if (bus.div_start) begin m_div = 1; m_dw = DT - 1; end
        else if (bus.branch_taken) m_fl = FL - 1;
        else if (bus.load_use_hazard) m_bub = LB - 1;
      end
    end
  end
  task automatic cyc(input logic r, dm, ds, dd, br, lu);
    @(posedge clk);
    #1;
    rst = r; bus.dm_stall = dm; bus.div_start = ds; bus.div_done = dd;
    bus.branch_taken = br; bus.load_use_hazard = lu;
    @(negedge clk);
  endtask
  task automatic wait_release(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (bus.pc_enable) break;
      n++;
    end
  endtask
  initial begin
    int n;
    bus.dm_stall = 0; bus.div_start = 0; bus.div_done = 0;
    bus.branch_taken = 0; bus.load_use_hazard = 0;
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_pc_en", int'(bus.pc_enable), 0);
    chk("rst_fd_flush", int'(bus.f_to_d_flush), 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("idle_pc_en", int'(bus.pc_enable), 1);
    chk("idle_count", int'(bus.stall_count), 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("lu1_fd_en", int'(bus.f_to_d_enable_ff), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lu2_pc_en", int'(bus.pc_enable), 0);
    chk("lu2_de_flush", int'(bus.d_to_e_flush), 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lu3_pc_en", int'(bus.pc_enable), 1);
    chk("lu3_count", int'(bus.stall_count), 2);
    cyc(0, 0, 0, 0, 1, 0);
    chk("br1_flush", int'(bus.f_to_d_flush), 1);
    chk("br1_pc_en", int'(bus.pc_enable), 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("br2_flush", int'(bus.f_to_d_flush), 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("br3_flush", int'(bus.f_to_d_flush), 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("br4_flush", int'(bus.f_to_d_flush), 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("div1_em_en", int'(bus.e_to_m_enable_ff), 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    chk("div4_pc_en", int'(bus.pc_enable), 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("div5_em_en", int'(bus.e_to_m_enable_ff), 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("div6_count", int'(bus.stall_count), 6);
    chk("div6_err", int'(bus.div_timeout_err), 0);
    cyc(0, 0, 1, 0, 1, 1);
    chk("prio_fd_flush", int'(bus.f_to_d_flush), 0);
    chk("prio_de_flush", int'(bus.d_to_e_flush), 0);
    repeat (10) cyc(0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0, 0);
    wait_release(n);
    chk("frozen_timeout_len", n, 69);
    cyc(0, 0, 0, 0, 0, 0);
    chk("timeout_err", int'(bus.div_timeout_err), 1);
    chk("timeout_count", int'(bus.stall_count), 89);
    cyc(0, 0, 1, 0, 0, 0);
    wait_release(n);
    chk("timeout_len", n, 79);
    cyc(0, 0, 0, 0, 0, 0);
    chk("err_sticky", int'(bus.div_timeout_err), 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_bubble_pc_en", int'(bus.pc_enable), 1);
    chk("rst_bubble_count", int'(bus.stall_count), 0);
    chk("rst_bubble_err", int'(bus.div_timeout_err), 0);
    repeat (4) begin
      cyc(0, 0, 1, 0, 0, 0);
      wait_release(n);
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk("count_saturated", int'(bus.stall_count), SMAX);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
